adder_tree_accumulator: RTL and testbench

- Consumer end of the adder_tree result interface.
- Takes the reduced sum stream (sum_out, qualified by start_out) and adds N consecutive valid beats into one frame total.
- Presents the frame total on a valid/ready output so wide vectors can be reduced in NUM_INPUTS-sized slices.
- Sits directly downstream of adder_tree in the datapath.

---
 rtl/adder_acc_pkg.sv | 19 +
 rtl/acc_sat_add.sv | 40 ++++
 rtl/adder_tree_accumulator.sv | 136 +++++++++++++
 tb/tb_adder_tree_accumulator.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_acc_pkg.sv
// Shared types and constants for the adder_tree result accumulator.
package adder_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } acc_state_e;

    localparam int unsigned ERR_CFG  = 0;
    localparam int unsigned ERR_DROP = 1;
    localparam int unsigned ERR_SAT  = 2;

    // Width that holds `beats` worst-case in_w-bit signed values without overflow.
    function automatic int acc_width(input int in_w, input int beats);
        return in_w + $clog2(beats);
    endfunction

endpackage

// File: rtl/acc_sat_add.sv
// Combinational signed add of a beat into the running total.
// Clamping on overflow is built only when ADDER_ACC_SAT_EN is defined.
module acc_sat_add
    import adder_acc_pkg::*;
#(
    parameter int IN_WIDTH  = 10,
    parameter int ACC_WIDTH = 14
) (
    input  logic signed [ACC_WIDTH-1:0] acc,
    input  logic signed [IN_WIDTH-1:0]  in_sum,
    output logic signed [ACC_WIDTH-1:0] sum,
    output logic                        ovf
);

    logic signed [ACC_WIDTH-1:0] in_ext;
    logic signed [ACC_WIDTH-1:0] raw_sum;

    assign in_ext  = ACC_WIDTH'(in_sum);
    assign raw_sum = acc + in_ext;

`ifdef ADDER_ACC_SAT_EN
    logic same_sign;

    // Overflow only when both operands share a sign that the result lacks.
    assign same_sign = (acc[ACC_WIDTH-1] == in_ext[ACC_WIDTH-1]);

    always_comb begin
        ovf = same_sign && (raw_sum[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);
        sum = raw_sum;
        if (ovf) begin
            sum = acc[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                   : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
    end
`else
    assign sum = raw_sum;
    assign ovf = 1'b0;
`endif

endmodule

// File: rtl/adder_tree_accumulator.sv
// Sums N valid beats of the adder_tree output into one frame total on a
// valid/ready interface. Optional saturation: define ADDER_ACC_SAT_EN.
module adder_tree_accumulator
    import adder_acc_pkg::*;
#(
    parameter int IN_WIDTH  = 10,
    parameter int MAX_BEATS = 16,
    parameter int CNT_WIDTH = $clog2(MAX_BEATS + 1),
    parameter int ACC_WIDTH = acc_width(IN_WIDTH, MAX_BEATS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        frame_start,
    input  logic [CNT_WIDTH-1:0]        num_beats,
    input  logic signed [IN_WIDTH-1:0]  in_sum,
    input  logic                        in_valid,
    output logic signed [ACC_WIDTH-1:0] acc_out,
    output logic                        acc_valid,
    input  logic                        acc_ready,
    output logic                        busy,
    output logic [2:0]                  err,
    input  logic                        err_clr
);

    acc_state_e                  state, state_d;
    logic signed [ACC_WIDTH-1:0] acc, acc_d;
    logic [CNT_WIDTH-1:0]        cnt, cnt_d, cnt_inc;
    logic [CNT_WIDTH-1:0]        beats_lat, beats_d;
    logic signed [ACC_WIDTH-1:0] acc_out_d;
    logic                        acc_valid_d;
    logic [2:0]                  err_set;
    logic                        cfg_legal;
    logic signed [ACC_WIDTH-1:0] add_sum;
    logic                        add_ovf;

    acc_sat_add #(
        .IN_WIDTH (IN_WIDTH),
        .ACC_WIDTH(ACC_WIDTH)
    ) u_add (
        .acc   (acc),
        .in_sum(in_sum),
        .sum   (add_sum),
        .ovf   (add_ovf)
    );

    assign cfg_legal = (num_beats != '0) && (num_beats <= CNT_WIDTH'(MAX_BEATS));
    assign cnt_inc   = cnt + 1'b1;

    always_comb begin
        state_d     = state;
        acc_d       = acc;
        cnt_d       = cnt;
        beats_d     = beats_lat;
        acc_out_d   = acc_out;
        acc_valid_d = acc_valid;
        err_set     = '0;

        case (state)
            IDLE: begin
                if (in_valid) err_set[ERR_DROP] = 1'b1;
                if (frame_start) begin
                    if (cfg_legal) begin
                        acc_d   = '0;
                        cnt_d   = '0;
                        beats_d = num_beats;
                        state_d = ACCUM;
                    end else begin
                        err_set[ERR_CFG] = 1'b1;
                    end
                end
            end

            ACCUM: begin
                if (frame_start) err_set[ERR_CFG] = 1'b1;
                if (in_valid) begin
                    acc_d = add_sum;
                    cnt_d = cnt_inc;
                    if (add_ovf) err_set[ERR_SAT] = 1'b1;
                    if (cnt_inc == beats_lat) begin
                        acc_out_d   = add_sum;
                        acc_valid_d = 1'b1;
                        state_d     = HOLD;
                    end
                end
            end

            HOLD: begin
                if (in_valid) err_set[ERR_DROP] = 1'b1;
                if (acc_ready) begin
                    acc_valid_d = 1'b0;
                    state_d     = IDLE;
                    // A legal frame_start during the handshake opens the next frame with no bubble.
                    if (frame_start && cfg_legal) begin
                        acc_d   = '0;
                        cnt_d   = '0;
                        beats_d = num_beats;
                        state_d = ACCUM;
                    end else if (frame_start) begin
                        err_set[ERR_CFG] = 1'b1;
                    end
                end else if (frame_start) begin
                    err_set[ERR_CFG] = 1'b1;
                end
            end

            default: begin
                state_d     = IDLE;
                acc_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            beats_lat <= '0;
            acc_out   <= '0;
            acc_valid <= 1'b0;
            busy      <= 1'b0;
            err       <= '0;
        end else begin
            state     <= state_d;
            acc       <= acc_d;
            cnt       <= cnt_d;
            beats_lat <= beats_d;
            acc_out   <= acc_out_d;
            acc_valid <= acc_valid_d;
            busy      <= (state_d != IDLE);
            // Set beats clear when both happen in one cycle.
            err       <= (err & ~{3{err_clr}}) | err_set;
        end
    end

endmodule

// File: tb/tb_adder_tree_accumulator.sv
// Directed self-checking bench for adder_tree_accumulator, with a second
// narrow (ACC_WIDTH=10) instance covering wrap / ADDER_ACC_SAT_EN clamp.
module tb_adder_tree_accumulator;

    localparam int IN_W  = 10;
    localparam int CNT_W = 5;
    localparam int ACC_W = 14;
    localparam int NAR_W = 10;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    frame_start;
    logic [CNT_W-1:0]        num_beats;
    logic signed [IN_W-1:0]  in_sum;
    logic                    in_valid;
    logic signed [ACC_W-1:0] acc_out;
    logic                    acc_valid;
    logic                    acc_ready;
    logic                    busy;
    logic [2:0]              err;
    logic                    err_clr;

    logic                    n_frame_start;
    logic [CNT_W-1:0]        n_num_beats;
    logic signed [IN_W-1:0]  n_in_sum;
    logic                    n_in_valid;
    logic signed [NAR_W-1:0] n_acc_out;
    logic                    n_acc_valid;
    logic                    n_acc_ready;
    logic                    n_busy;
    logic [2:0]              n_err;
    logic                    n_err_clr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    adder_tree_accumulator u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_start(frame_start),
        .num_beats  (num_beats),
        .in_sum     (in_sum),
        .in_valid   (in_valid),
        .acc_out    (acc_out),
        .acc_valid  (acc_valid),
        .acc_ready  (acc_ready),
        .busy       (busy),
        .err        (err),
        .err_clr    (err_clr)
    );

    adder_tree_accumulator #(.ACC_WIDTH(NAR_W)) u_dut_narrow (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_start(n_frame_start),
        .num_beats  (n_num_beats),
        .in_sum     (n_in_sum),
        .in_valid   (n_in_valid),
        .acc_out    (n_acc_out),
        .acc_valid  (n_acc_valid),
        .acc_ready  (n_acc_ready),
        .busy       (n_busy),
        .err        (n_err),
        .err_clr    (n_err_clr)
    );

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic open_frame(input int n);
        frame_start = 1'b1;
        num_beats   = CNT_W'(n);
        step();
        frame_start = 1'b0;
    endtask

    task automatic beat(input int v);
        in_valid = 1'b1;
        in_sum   = IN_W'(v);
        step();
        in_valid = 1'b0;
    endtask

    task automatic handshake();
        acc_ready = 1'b1;
        step();
        acc_ready = 1'b0;
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; frame_start = 1'b0; num_beats = '0; in_sum = '0;
        in_valid = 1'b0; acc_ready = 1'b0; err_clr = 1'b0;
        n_frame_start = 1'b0; n_num_beats = '0; n_in_sum = '0;
        n_in_valid = 1'b0; n_acc_ready = 1'b0; n_err_clr = 1'b0;
        step(); step();
        check("rst_acc_out", acc_out, 0);
        check("rst_acc_valid", acc_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;
        step();

        // Basic frame: 100 - 20 + 7 + 255 = 342
        open_frame(4);
        check("basic_busy", busy, 1);
        beat(100); beat(-20); beat(7);
        check("basic_not_yet_valid", acc_valid, 0);
        beat(255);
        check("basic_valid", acc_valid, 1);
        check("basic_sum", acc_out, 342);
        check("basic_err", err, 0);

        // Backpressure with a stray beat in HOLD
        for (int unsigned i = 0; i < 5; i++) begin
            in_valid = (i == 2);
            in_sum   = 10'sd50;
            step();
            check("hold_valid", acc_valid, 1);
            check("hold_sum", acc_out, 342);
        end
        in_valid = 1'b0;
        check("hold_drop_err", err, 3'b010);

        // Back-to-back: handshake and legal frame_start together
        acc_ready = 1'b1; frame_start = 1'b1; num_beats = 5'd2;
        step();
        acc_ready = 1'b0; frame_start = 1'b0;
        check("b2b_valid_fell", acc_valid, 0);
        check("b2b_busy", busy, 1);
        beat(1); beat(2);
        check("b2b_valid", acc_valid, 1);
        check("b2b_sum", acc_out, 3);
        handshake();
        check("b2b_idle_busy", busy, 0);
        check("b2b_idle_valid", acc_valid, 0);
        clear_err();
        check("err_cleared", err, 0);

        // Config errors
        open_frame(0);
        check("cfg0_err", err, 3'b001);
        check("cfg0_busy", busy, 0);
        clear_err();
        open_frame(17);
        check("cfg17_err", err, 3'b001);
        check("cfg17_busy", busy, 0);
        clear_err();
        open_frame(3);
        beat(10);
        open_frame(2);
        check("cfg_mid_err", err, 3'b001);
        check("cfg_mid_busy", busy, 1);
        beat(20);
        check("cfg_mid_not_done", acc_valid, 0);
        beat(30);
        check("cfg_mid_valid", acc_valid, 1);
        check("cfg_mid_sum", acc_out, 60);
        handshake();

        // Same-cycle err set and clear: set wins
        err_clr = 1'b1; frame_start = 1'b1; num_beats = 5'd0;
        step();
        err_clr = 1'b0; frame_start = 1'b0;
        check("set_beats_clr", err, 3'b001);

        // Beat arriving with frame_start in IDLE is not counted
        clear_err();
        frame_start = 1'b1; num_beats = 5'd1; in_valid = 1'b1; in_sum = 10'sd99;
        step();
        frame_start = 1'b0; in_valid = 1'b0;
        check("fs_beat_drop_err", err, 3'b010);
        check("fs_beat_not_done", acc_valid, 0);
        beat(4);
        check("fs_beat_sum", acc_out, 4);
        handshake();
        clear_err();

        // Extremes
        open_frame(16);
        for (int unsigned i = 0; i < 16; i++) beat(-512);
        check("min_valid", acc_valid, 1);
        check("min_sum", acc_out, -8192);
        handshake();
        open_frame(16);
        for (int unsigned i = 0; i < 16; i++) beat(511);
        check("max_sum", acc_out, 8176);
        check("max_err", err, 0);
        handshake();

        // Reset mid-frame after stirring up an error flag
        open_frame(4);
        beat(40); beat(41);
        open_frame(2);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midrst_valid", acc_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_err", err, 0);
        open_frame(1);
        beat(5);
        check("midrst_new_valid", acc_valid, 1);
        check("midrst_new_sum", acc_out, 5);
        handshake();

        // Narrow accumulator: 400 + 400 overflows 10 bits
        n_frame_start = 1'b1; n_num_beats = 5'd2;
        step();
        n_frame_start = 1'b0;
        n_in_valid = 1'b1; n_in_sum = 10'sd400;
        step(); step();
        n_in_valid = 1'b0;
        check("narrow_valid", n_acc_valid, 1);
`ifdef ADDER_ACC_SAT_EN
        check("narrow_sat_sum", n_acc_out, 511);
        check("narrow_sat_err", n_err, 3'b100);
`else
        check("narrow_wrap_sum", n_acc_out, -224);
        check("narrow_wrap_err", n_err, 3'b000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
